// File: rtl/lsu_pkg.sv
// Shared encodings and constants for the load/store unit controller.
package lsu_pkg;

    localparam int unsigned LsuLanes      = 4;
    localparam int unsigned LsuDataW      = 32;
    localparam int unsigned TIMEOUT_LIMIT = 15;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } lsu_size_e;

    // Unsupported encodings fall back to word size.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3Byte, F3ByteU: return SizeByte;
            F3Half, F3HalfU: return SizeHalf;
            default:         return SizeWord;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [LsuDataW-1:0] rdata_i,
    input  logic [1:0]          offset_i,
    input  logic [2:0]          funct3_i,
    output logic [LsuDataW-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3Byte:  data_o = {{24{byte_sel[7]}}, byte_sel};
            F3ByteU: data_o = {24'h0, byte_sel};
            F3Half:  data_o = {{16{half_sel[15]}}, half_sel};
            F3HalfU: data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one bus transaction per access, with stall,
// misalignment detection, store lane steering and a bus timeout.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         lsu_addr_i,
    input  logic [31:0]         lsu_wdata_i,
    input  logic                lsu_rden_i,
    input  logic                lsu_wren_i,
    input  logic [2:0]          funct3_i,
    output logic [31:0]         lsu_ld_data_o,
    output logic                stall_o,
    output logic                misalign_o,
    output logic                err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic [LsuLanes-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [31:0]         mem_rdata_i
);

    lsu_state_e          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         ld_q, ld_d;
    logic                err_q, err_d;
    logic [31:0]         addr_q, wdata_q;
    logic                we_q;
    logic [LsuLanes-1:0] be_q;
    logic [1:0]          off_q;
    logic [2:0]          f3_q;

    lsu_size_e           size;
    logic                access, misalign, start, timeout;
    logic [LsuLanes-1:0] be_new;
    logic [31:0]         wdata_new, ld_aligned;

    assign access  = lsu_rden_i | lsu_wren_i;
    assign size    = f3_size(funct3_i);
    assign timeout = (cnt_q == 4'(TIMEOUT_LIMIT));

    always_comb begin
        case (size)
            SizeWord: misalign = (lsu_addr_i[1:0] != 2'b00);
            SizeHalf: misalign = lsu_addr_i[0];
            default:  misalign = 1'b0;
        endcase
    end

    always_comb begin
        case (size)
            SizeByte: begin
                be_new    = 4'b0001 << lsu_addr_i[1:0];
                wdata_new = {4{lsu_wdata_i[7:0]}};
            end
            SizeHalf: begin
                be_new    = 4'b0011 << lsu_addr_i[1:0];
                wdata_new = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = lsu_wdata_i;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata_i  (mem_rdata_i),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_aligned)
    );

    assign start = (state_q == StIdle) && access && !misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (start) state_d = StReq;
            end
            StReq: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (mem_ack_i) begin
                    state_d = StDone;
                    if (!we_q) ld_d = ld_aligned;
                end else if (timeout) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    ld_d    = 32'h0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            ld_q    <= 32'h0;
            err_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= '0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            if (start) begin
                addr_q  <= {lsu_addr_i[31:2], 2'b00};
                wdata_q <= wdata_new;
                we_q    <= lsu_wren_i;
                be_q    <= be_new;
                off_q   <= lsu_addr_i[1:0];
                f3_q    <= funct3_i;
            end
        end
    end

    assign misalign_o    = access && misalign;
    assign stall_o       = start || (state_q == StReq);
    assign lsu_ld_data_o = misalign_o ? 32'h0 : ld_q;
    assign err_o         = err_q;
    assign mem_req_o     = (state_q == StReq);
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_be_o      = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed cases plus randomized accesses.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_rden_i, lsu_wren_i;
    logic [2:0]  funct3_i;
    logic [31:0] lsu_ld_data_o;
    logic        stall_o, misalign_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_rden_i    (lsu_rden_i),
        .lsu_wren_i    (lsu_wren_i),
        .funct3_i      (funct3_i),
        .lsu_ld_data_o (lsu_ld_data_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .err_o         (err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        err;
        logic [31:0] ld;
    } res_t;

    bus_t        bus_q[$];
    res_t        res_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ld_model = 32'h0;
    bit          abandon  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    // Drive an access and queue the bus transaction it should produce.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_t b;
        int   sz;
        lsu_rden_i  = rd;
        lsu_wren_i  = wr;
        funct3_i    = f3;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        sz = size_of(f3);
        if ((rd || wr) && (addr % sz == 0)) begin
            b.addr  = addr & ~32'h3;
            b.we    = wr;
            b.be    = (sz == 4) ? 4'hf : ((sz == 2 ? 4'h3 : 4'h1) << addr[1:0]);
            b.wdata = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
            bus_q.push_back(b);
        end
    endtask

    // ack_at: index of the REQ cycle that sees the ack; >= 16 means no ack.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_at, input logic [31:0] rdata);
        res_t r;
        int   stalls;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        issue(rd, wr, f3, addr, wdata);
        if (ack_at >= 16) ld_model = 32'h0;
        else if (!wr) ld_model = load_model(f3, addr[1:0], rdata);
        r.err = (ack_at >= 16);
        r.ld  = ld_model;
        res_q.push_back(r);
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall_o) break;
            stalls++;
            @(posedge clk); #1;
            mem_ack_i   = (c == ack_at);
            mem_rdata_i = (c == ack_at) ? rdata : $urandom;
        end
        check("stall_cycles", stalls, ((ack_at < 16) ? ack_at : 15) + 2);
        @(posedge clk); #1;
        mem_ack_i  = 1'b0;
        lsu_rden_i = 1'b0;
        lsu_wren_i = 1'b0;
        @(negedge clk);
        check("ld_hold", lsu_ld_data_o, ld_model);
    endtask

    // Monitor: compares bus fields every REQ cycle, and results on the DONE cycle.
    initial begin
        bit   prev;
        bus_t cur;
        prev = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!prev) begin
                    if (bus_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_req: got addr %h with no access queued",
                                 mem_addr_o);
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check("mem_addr", mem_addr_o, cur.addr);
                check("mem_we", 32'(mem_we_o), 32'(cur.we));
                if (cur.we) begin
                    check("mem_be", 32'(mem_be_o), 32'(cur.be));
                    check("mem_wdata", mem_wdata_o, cur.wdata);
                end
            end else if (prev && !rst_i) begin
                if (abandon) begin
                    abandon = 1'b0;
                    check("err_after_abort", 32'(err_o), 32'h0);
                end else if (res_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got ld %h with no result queued",
                             lsu_ld_data_o);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("err_pulse", 32'(err_o), 32'(r.err));
                    check("ld_data", lsu_ld_data_o, r.ld);
                end
            end else if (!rst_i) begin
                check("err_idle", 32'(err_o), 32'h0);
            end
            prev = mem_req_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        lsu_addr_i  = 32'h0;
        lsu_wdata_i = 32'h0;
        lsu_rden_i  = 1'b0;
        lsu_wren_i  = 1'b0;
        funct3_i    = 3'b000;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_ld", lsu_ld_data_o, 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_be", 32'(mem_be_o), 32'h0);
        check("rst_we", 32'(mem_we_o), 32'h0);

        do_access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        check("lw_deadbeef", lsu_ld_data_o, 32'hDEADBEEF);
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
        check("lb_sext", lsu_ld_data_o, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80112233);
        check("lbu_zext", lsu_ld_data_o, 32'h00000080);
        do_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233);
        check("lhu_zext", lsu_ld_data_o, 32'h00008011);
        do_access(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, 32'h0);
        check("sh_keeps_ld", lsu_ld_data_o, 32'h00008011);

        // Misaligned word load: flagged, no bus request, no stall.
        @(posedge clk); #1;
        issue(1, 0, 3'b010, 32'h101, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("mis_flag", 32'(misalign_o), 32'h1);
            check("mis_stall", 32'(stall_o), 32'h0);
            check("mis_ld", lsu_ld_data_o, 32'h0);
            check("mis_req", 32'(mem_req_o), 32'h0);
        end
        @(posedge clk); #1;
        lsu_rden_i = 1'b0;

        do_access(1, 0, 3'b010, 32'h104, 32'h0, 99, 32'h0);
        check("timeout_ld", lsu_ld_data_o, 32'h0);
        do_access(1, 0, 3'b010, 32'h108, 32'h0, 15, 32'h12345678);
        check("ack_at_limit", lsu_ld_data_o, 32'h12345678);

        // Reset during the second REQ cycle abandons the transaction.
        @(posedge clk); #1;
        issue(1, 0, 3'b010, 32'h200, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abandon = 1'b1;
        rst_i   = 1'b1;
        @(posedge clk); #1;
        rst_i      = 1'b0;
        lsu_rden_i = 1'b0;
        ld_model   = 32'h0;
        @(negedge clk);
        check("rst_req_drop", 32'(mem_req_o), 32'h0);
        check("rst_req_stall", 32'(stall_o), 32'h0);
        check("rst_req_ld", lsu_ld_data_o, 32'h0);
        @(posedge clk); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("late_ack_req", 32'(mem_req_o), 32'h0);
        check("late_ack_ld", lsu_ld_data_o, 32'h0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  f3;
            logic [1:0]  rw;
            logic [31:0] addr;
            int          sz, ack_at;
            f3   = 3'($urandom_range(0, 7));
            rw   = 2'($urandom_range(1, 3));
            sz   = size_of(f3);
            addr = $urandom;
            addr = addr & ~(32'(sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) ack_at = $urandom_range(0, 1) ? 99 : 15;
            else ack_at = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
            end
            do_access(rw[0], rw[1], f3, addr, $urandom, ack_at, $urandom);
        end

        repeat (3) @(posedge clk);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        check("res_q_drained", 32'(res_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk_i  in  1  single clock, all state on rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 lsu_addr_i  in  32  byte address from the ALU.
REQ-004 lsu_wdata_i  in  32  store data (rs2).
REQ-005 lsu_rden_i  in  1  load request.
REQ-006 lsu_wren_i  in  1  store request.
REQ-007 funct3_i  in  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 lsu_ld_data_o  out  32  aligned, extended load data; feeds the writeback-select input for loads.
REQ-009 stall_o  out  1  core hold (PC and register file write enable gated).
REQ-010 misalign_o  out  1  misaligned access flag, combinational.
REQ-011 err_o  out  1  one-cycle bus timeout pulse.
REQ-012 mem_req_o / mem_we_o  out  1/1  bus request and write strobe.
REQ-013 mem_addr_o  out  32  word-aligned address, {lsu_addr_i[31:2],2'b00}.
REQ-014 mem_wdata_o / mem_be_o  out  32/4  lane-replicated store data and byte enables.
REQ-015 mem_ack_i / mem_rdata_i  in  1/32  bus completion and read word.

Function
REQ-016 FSM states: IDLE, REQ, DONE.
- IDLE -> REQ: access present (rden|wren), aligned.
- REQ -> DONE: mem_ack_i, or timeout.
- DONE -> IDLE: unconditionally.
REQ-017 mem_req_o = (state==REQ); mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are registered on IDLE->REQ and held stable through REQ.
REQ-018 stall_o = 1 in IDLE with an aligned access present, and in REQ; 0 in DONE and otherwise, giving an access latency of ack-cycle + 1 stalled cycles.
REQ-019 Requests seen in DONE are ignored (the same instruction retiring); the next access is sampled in IDLE.
REQ-020 If rden and wren are both high, the access is a store.
REQ-021 Misaligned access:
- Conditions: word with addr[1:0]!=0, or half with addr[0]!=0.
- misalign_o=1, no bus request, stall_o=0, lsu_ld_data_o=0.
REQ-022 Store enables:
- SB: be = 0001<<addr[1:0], wdata = {4{byte}}.
- SH: be = 0011<<addr[1:0], wdata = {2{half}}.
- SW: be = 1111.
REQ-023 Load data:
- Captured from mem_rdata_i on the ack cycle and selected by byte lane addr[1:0].
- Sign-extended for LB/LH, zero-extended for LBU/LHU, passed whole for LW.
- Held in a register until the next load completes.
REQ-024 Timeout:
- A 4-bit counter clears on entry to REQ and increments each REQ cycle without ack.
- At count 15 without ack: go to DONE, pulse err_o in DONE, load register = 0.
- Ack in the same cycle as count 15: ack wins, no error.
REQ-025 Store completion: lsu_ld_data_o is unchanged.
REQ-026 mem_ack_i outside REQ is ignored.
REQ-027 Unsupported funct3 (011, 110, 111) is treated as LW/SW size with zero-extension.

Reset
REQ-028 Reset values:
- State IDLE; counter 0.
- All registered bus outputs 0; lsu_ld_data_o = 0; err_o = 0.
REQ-029 Reset asserted in REQ: mem_req_o = 0 from the next edge; the transaction is abandoned; a later ack is ignored.
REQ-030 Reset dominates all other transitions at the edge.

Structure
REQ-031 lsu_pkg:
- funct3 encodings.
- FSM state enum.
- TIMEOUT_LIMIT = 15.
- Lane/byte-enable width constants.
REQ-032 One combinational sub-module lsu_load_align: lane select plus sign/zero extension.
REQ-033 Store lane logic and the FSM remain in lsu_ctrl.

Verification
REQ-034 LW addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF -> stall_o high 3 cycles, then lsu_ld_data_o = 0xDEADBEEF.
REQ-035 LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-036 SH addr 0x102, wdata 0x0000ABCD -> mem_be_o 1100, mem_wdata_o 0xABCDABCD, mem_we_o 1, held until ack.
REQ-037 LW addr 0x101 -> misalign_o 1, mem_req_o never asserts, stall_o 0.
REQ-038 LW with no ack -> 16 REQ cycles, err_o pulse, lsu_ld_data_o 0; ack on the 16th cycle -> no err_o, data captured.
REQ-039 rst_i in the 2nd REQ cycle -> IDLE next edge, mem_req_o 0, later ack ignored, lsu_ld_data_o 0.
